// File: rtl/pfb_deadlock_watchdog_if.sv
// Handshake bundle between the pfb_multichannel harness and its deadlock watchdog.
// The master side drives the monitor flags, progress strobe and clear; the slave reports.
interface pfb_deadlock_watchdog_if #(
   parameter int NUM_MON = 8,
   parameter int IDX_W   = 3,
   parameter int CNT_W   = 16,
   parameter int STAMP_W = 32
);
   logic [NUM_MON-1:0] mon_block;
   logic               progress;
   logic               clear;
   logic               deadlock;
   logic               deadlock_pulse;
   logic [IDX_W-1:0]   first_idx;
   logic [CNT_W-1:0]   stall_cycles;
   logic [STAMP_W-1:0] cycle_stamp;

   modport master (
      output mon_block, progress, clear,
      input  deadlock, deadlock_pulse, first_idx, stall_cycles, cycle_stamp
   );

   modport slave (
      input  mon_block, progress, clear,
      output deadlock, deadlock_pulse, first_idx, stall_cycles, cycle_stamp
   );
endinterface

// File: rtl/pfb_deadlock_watchdog.sv
// Declares a deadlock once any monitor has been blocked for THRESHOLD consecutive
// cycles with no design progress, and records who blocked first and when.
module pfb_deadlock_watchdog #(
   parameter int NUM_MON   = 8,
   parameter int IDX_W     = 3,
   parameter int THRESHOLD = 1000,
   parameter int CNT_W     = 16,
   parameter int STAMP_W   = 32
) (
   input logic                  clock,
   input logic                  reset_n,
   pfb_deadlock_watchdog_if.slave bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SUSPECT  = 2'd1;
   localparam logic [1:0] ST_DEADLOCK = 2'd2;

   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);

   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MON-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_MON - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   logic [1:0]         state_r,  state_s;
   logic [CNT_W-1:0]   stall_r,  stall_s;
   logic [IDX_W-1:0]   idx_r,    idx_s;
   logic [STAMP_W-1:0] cap_r,    cap_s;
   logic               dl_r,     dl_s;
   logic               pulse_r,  pulse_s;
   logic [STAMP_W-1:0] stamp_r;
   logic               qual_s;
   logic [CNT_W-1:0]   stall_inc_s;

   // Progress in the same cycle overrides any block flag.
   assign qual_s      = (|bus.mon_block) & ~bus.progress;
   assign stall_inc_s = (stall_r == {CNT_W{1'b1}}) ? stall_r : stall_r + CNT_W'(1);

   // Next-state and report update; clear beats every state.
   always_comb begin
      state_s = state_r;
      stall_s = stall_r;
      idx_s   = idx_r;
      cap_s   = cap_r;
      dl_s    = dl_r;
      pulse_s = 1'b0;
      if (bus.clear) begin
         state_s = ST_IDLE;
         stall_s = '0;
         idx_s   = '0;
         cap_s   = '0;
         dl_s    = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (qual_s) begin
                  stall_s = CNT_W'(1);
                  idx_s   = lowest_set(bus.mon_block);
                  if (THRESHOLD == 1) begin
                     state_s = ST_DEADLOCK;
                     dl_s    = 1'b1;
                     pulse_s = 1'b1;
                     cap_s   = stamp_r;
                  end else begin
                     state_s = ST_SUSPECT;
                  end
               end else begin
                  stall_s = '0;
               end
            end
            ST_SUSPECT: begin
               if (qual_s) begin
                  stall_s = stall_inc_s;
                  if (stall_inc_s == THRESH_C) begin
                     state_s = ST_DEADLOCK;
                     dl_s    = 1'b1;
                     pulse_s = 1'b1;
                     cap_s   = stamp_r;
                  end else begin
                     state_s = ST_SUSPECT;
                  end
               end else begin
                  state_s = ST_IDLE;
                  stall_s = '0;
               end
            end
            ST_DEADLOCK: begin
               // Report is frozen; only the stall length keeps growing.
               if (qual_s) begin
                  stall_s = stall_inc_s;
               end else begin
                  stall_s = stall_r;
               end
            end
            default: begin
               state_s = ST_IDLE;
               stall_s = '0;
               idx_s   = '0;
               cap_s   = '0;
               dl_s    = 1'b0;
            end
         endcase
      end
   end

   // State, report registers and free-running cycle stamp.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         stall_r <= '0;
         idx_r   <= '0;
         cap_r   <= '0;
         dl_r    <= 1'b0;
         pulse_r <= 1'b0;
         stamp_r <= '0;
      end else begin
         state_r <= state_s;
         stall_r <= stall_s;
         idx_r   <= idx_s;
         cap_r   <= cap_s;
         dl_r    <= dl_s;
         pulse_r <= pulse_s;
         stamp_r <= stamp_r + STAMP_W'(1);
      end
   end

   assign bus.deadlock       = dl_r;
   assign bus.deadlock_pulse = pulse_r;
   assign bus.first_idx      = idx_r;
   assign bus.stall_cycles   = stall_r;
   assign bus.cycle_stamp    = cap_r;

endmodule

// File: tb/tb_pfb_deadlock_watchdog.sv
// Directed bench for pfb_deadlock_watchdog: one instance with THRESHOLD=4, one with THRESHOLD=1.
module tb_pfb_deadlock_watchdog;

   logic clock;
   logic rst_a_n;
   logic rst_b_n;
   int   errors;
   int   checks;
   int   cyc_a;
   int   cyc_b;
   int   start_cyc;
   int   pulse_seen;

   pfb_deadlock_watchdog_if #(.NUM_MON(8), .IDX_W(3), .CNT_W(16), .STAMP_W(32)) bus_a ();
   pfb_deadlock_watchdog_if #(.NUM_MON(8), .IDX_W(3), .CNT_W(16), .STAMP_W(32)) bus_b ();

   pfb_deadlock_watchdog #(.NUM_MON(8), .IDX_W(3), .THRESHOLD(4), .CNT_W(16), .STAMP_W(32)) dut_a (
      .clock  (clock),
      .reset_n(rst_a_n),
      .bus    (bus_a)
   );

   pfb_deadlock_watchdog #(.NUM_MON(8), .IDX_W(3), .THRESHOLD(1), .CNT_W(16), .STAMP_W(32)) dut_b (
      .clock  (clock),
      .reset_n(rst_b_n),
      .bus    (bus_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic tick();
      @(posedge clock);
      cyc_a++;
      cyc_b++;
      @(negedge clock);
   endtask

   task automatic check_a(input string tag, input logic dl, input logic pl,
                          input logic [2:0] idx, input logic [15:0] st);
      check({tag, ".deadlock"}, 64'(bus_a.deadlock), 64'(dl));
      check({tag, ".pulse"},    64'(bus_a.deadlock_pulse), 64'(pl));
      check({tag, ".first_idx"}, 64'(bus_a.first_idx), 64'(idx));
      check({tag, ".stall"},    64'(bus_a.stall_cycles), 64'(st));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc_a  = 0;
      cyc_b  = 0;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      bus_a.mon_block = 8'h00;
      bus_a.progress  = 1'b0;
      bus_a.clear     = 1'b0;
      bus_b.mon_block = 8'h00;
      bus_b.progress  = 1'b0;
      bus_b.clear     = 1'b0;

      // Reset state, with qualifying input present to show reset dominates.
      @(negedge clock);
      bus_a.mon_block = 8'hFF;
      repeat (3) @(negedge clock);
      check_a("reset", 1'b0, 1'b0, 3'd0, 16'd0);
      check("reset.stamp", 64'(bus_a.cycle_stamp), 64'd0);
      bus_a.mon_block = 8'h00;
      rst_a_n = 1'b1;
      cyc_a = 0;

      // Test 1: single monitor blocked for THRESHOLD cycles.
      bus_a.mon_block = 8'h10;
      start_cyc = cyc_a;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_a($sformatf("t1.c%0d", i), 1'b0, 1'b0, 3'd4, 16'(i));
      end
      tick();
      check_a("t1.entry", 1'b1, 1'b1, 3'd4, 16'd4);
      check("t1.stamp", 64'(bus_a.cycle_stamp), 64'(start_cyc + 3));
      bus_a.mon_block = 8'h00;
      tick();
      check_a("t1.hold", 1'b1, 1'b0, 3'd4, 16'd4);
      bus_a.clear = 1'b1;
      tick();
      check_a("t1.clear", 1'b0, 1'b0, 3'd0, 16'd0);
      check("t1.clear_stamp", 64'(bus_a.cycle_stamp), 64'd0);
      bus_a.clear = 1'b0;

      // Test 2: progress breaks the run; first_idx keeps its last value.
      bus_a.mon_block = 8'h24;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_a($sformatf("t2.c%0d", i), 1'b0, 1'b0, 3'd2, 16'(i));
      end
      bus_a.progress = 1'b1;
      tick();
      check_a("t2.progress", 1'b0, 1'b0, 3'd2, 16'd0);
      bus_a.progress = 1'b0;
      tick();
      check_a("t2.restart", 1'b0, 1'b0, 3'd2, 16'd1);
      bus_a.mon_block = 8'h00;
      tick();
      check_a("t2.idle", 1'b0, 1'b0, 3'd2, 16'd0);

      // Test 3: long stall saturates the counter; pulse fires only once.
      bus_a.mon_block = 8'h01;
      start_cyc = cyc_a;
      repeat (4) tick();
      check_a("t3.entry", 1'b1, 1'b1, 3'd0, 16'd4);
      check("t3.stamp", 64'(bus_a.cycle_stamp), 64'(start_cyc + 3));
      tick();
      check_a("t3.after", 1'b1, 1'b0, 3'd0, 16'd5);
      pulse_seen = 0;
      for (int i = 0; i < 70000; i++) begin
         tick();
         if (bus_a.deadlock_pulse) pulse_seen++;
      end
      check_a("t3.sat", 1'b1, 1'b0, 3'd0, 16'hFFFF);
      check("t3.pulses", 64'(pulse_seen), 64'd0);
      check("t3.stamp_frozen", 64'(bus_a.cycle_stamp), 64'(start_cyc + 3));

      // Test 4: clear while still blocked, then re-declare.
      bus_a.mon_block = 8'h80;
      bus_a.clear = 1'b1;
      tick();
      check_a("t4.clear", 1'b0, 1'b0, 3'd0, 16'd0);
      check("t4.clear_stamp", 64'(bus_a.cycle_stamp), 64'd0);
      bus_a.clear = 1'b0;
      start_cyc = cyc_a;
      tick();
      check_a("t4.c1", 1'b0, 1'b0, 3'd7, 16'd1);
      repeat (2) tick();
      check_a("t4.c3", 1'b0, 1'b0, 3'd7, 16'd3);
      tick();
      check_a("t4.entry", 1'b1, 1'b1, 3'd7, 16'd4);
      check("t4.stamp", 64'(bus_a.cycle_stamp), 64'(start_cyc + 3));

      // Test 5: asynchronous reset mid-SUSPECT.
      bus_a.mon_block = 8'h00;
      bus_a.clear = 1'b1;
      tick();
      bus_a.clear = 1'b0;
      bus_a.mon_block = 8'h02;
      repeat (3) tick();
      check_a("t5.pre", 1'b0, 1'b0, 3'd1, 16'd3);
      #2;
      rst_a_n = 1'b0;
      #1;
      check_a("t5.async", 1'b0, 1'b0, 3'd0, 16'd0);
      @(negedge clock);
      rst_a_n = 1'b1;
      cyc_a = 0;
      repeat (3) tick();
      check_a("t5.c3", 1'b0, 1'b0, 3'd1, 16'd3);
      tick();
      check_a("t5.entry", 1'b1, 1'b1, 3'd1, 16'd4);
      check("t5.stamp", 64'(bus_a.cycle_stamp), 64'd3);
      bus_a.mon_block = 8'h00;

      // Test 6: THRESHOLD=1, single qualifying cycle while stamp=100.
      rst_b_n = 1'b1;
      cyc_b = 0;
      repeat (100) tick();
      check("t6.quiet", 64'(bus_b.deadlock), 64'd0);
      bus_b.mon_block = 8'h08;
      tick();
      bus_b.mon_block = 8'h00;
      check("t6.deadlock", 64'(bus_b.deadlock), 64'd1);
      check("t6.pulse", 64'(bus_b.deadlock_pulse), 64'd1);
      check("t6.stamp", 64'(bus_b.cycle_stamp), 64'd100);
      check("t6.stall", 64'(bus_b.stall_cycles), 64'd1);
      check("t6.first_idx", 64'(bus_b.first_idx), 64'd3);
      tick();
      check("t6.pulse_off", 64'(bus_b.deadlock_pulse), 64'd0);
      check("t6.sticky", 64'(bus_b.deadlock), 64'd1);
      check("t6.stall_hold", 64'(bus_b.stall_cycles), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
